// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-request memory unit.
// Port 0 is a read-only fetch port, port 1 is a read/write data port; a watchdog aborts stuck waits.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic                  p0_ack,
    output logic                  p0_done,
    input  logic                  p1_req,
    input  logic                  p1_rwn,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [31:0]           p1_wdata,
    output logic                  p1_ack,
    output logic                  p1_done,
    output logic [31:0]           rd_data,
    output logic                  mem_enable,
    output logic                  mem_rwn,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_done,
    output logic                  timeout
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [15:0] CountMax = 16'(TIMEOUT - 1);

    state_e      state;
    logic        last_grant;  // 1 = port 1 was granted most recently
    logic        owner;       // port owning the transaction in flight
    logic [15:0] count;
    logic        grant1;

    // Port 1 wins when alone, or when both request and port 0 went last.
    always_comb begin
        grant1 = p1_req & (~p0_req | ~last_grant);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= StIdle;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            count      <= 16'd0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_done    <= 1'b0;
            p1_done    <= 1'b0;
            rd_data    <= 32'd0;
            mem_enable <= 1'b0;
            mem_rwn    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            timeout    <= 1'b0;
        end else begin
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_done    <= 1'b0;
            p1_done    <= 1'b0;
            mem_enable <= 1'b0;
            timeout    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (p0_req || p1_req) begin
                        state      <= StIssue;
                        owner      <= grant1;
                        last_grant <= grant1;
                        p0_ack     <= ~grant1;
                        p1_ack     <= grant1;
                        mem_enable <= 1'b1;
                        count      <= 16'd0;
                        if (grant1) begin
                            mem_addr  <= p1_addr;
                            mem_rwn   <= p1_rwn;
                            mem_wdata <= p1_wdata;
                        end else begin
                            mem_addr  <= p0_addr;
                            mem_rwn   <= 1'b1;
                            mem_wdata <= 32'd0;
                        end
                    end
                end
                StIssue: begin
                    state <= StWait;
                    count <= 16'd0;
                end
                StWait: begin
                    if (mem_done) begin
                        state   <= StIdle;
                        p0_done <= ~owner;
                        p1_done <= owner;
                        if (mem_rwn) begin
                            rd_data <= mem_rdata;
                        end
                    end else if (count == CountMax) begin
                        state   <= StIdle;
                        p0_done <= ~owner;
                        p1_done <= owner;
                        timeout <= 1'b1;
                        rd_data <= 32'hFFFF_FFFF;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: drives both ports and a memory model, and predicts
// grants, latched fields, completion timing and rd_data from a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 27;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          p0_req, p0_ack, p0_done;
    logic [AW-1:0] p0_addr;
    logic          p1_req, p1_rwn, p1_ack, p1_done;
    logic [AW-1:0] p1_addr;
    logic [31:0]   p1_wdata;
    logic [31:0]   rd_data;
    logic          mem_enable, mem_rwn, mem_done, timeout;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int          n_vec = 0;
    int          n_err = 0;
    int          last_grant;   // model: port granted most recently
    logic [31:0] exp_rd;       // model: expected rd_data

    mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .p0_req     (p0_req),
        .p0_addr    (p0_addr),
        .p0_ack     (p0_ack),
        .p0_done    (p0_done),
        .p1_req     (p1_req),
        .p1_rwn     (p1_rwn),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p1_ack     (p1_ack),
        .p1_done    (p1_done),
        .rd_data    (rd_data),
        .mem_enable (mem_enable),
        .mem_rwn    (mem_rwn),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pulses"}, 32'({p0_ack, p1_ack, p0_done, p1_done, mem_enable, timeout}), 0);
        check_eq({tag, "_rwn"}, 32'(mem_rwn), 0);
        check_eq({tag, "_addr"}, 32'(mem_addr), 0);
        check_eq({tag, "_wdata"}, mem_wdata, 0);
        check_eq({tag, "_rd"}, rd_data, 0);
    endtask

    // Entered #1 after an edge with the arbiter idle and requests already driven.
    task automatic run_txn(input int lat, input logic [31:0] rdata);
        int          w;
        int          ncyc;
        bit          to;
        logic [31:0] ea, ew;
        logic        er;
        w = (p0_req && p1_req) ? 1 - last_grant : (p1_req ? 1 : 0);
        if (w == 0) begin
            ea = 32'(p0_addr); er = 1'b1; ew = 32'd0;
        end else begin
            ea = 32'(p1_addr); er = p1_rwn; ew = p1_wdata;
        end
        last_grant = w;
        @(posedge clk); #1;
        check_eq("p0_ack", 32'(p0_ack), 32'(w == 0));
        check_eq("p1_ack", 32'(p1_ack), 32'(w == 1));
        check_eq("mem_enable", 32'(mem_enable), 1);
        check_eq("mem_addr", 32'(mem_addr), ea);
        check_eq("mem_rwn", 32'(mem_rwn), 32'(er));
        check_eq("mem_wdata", mem_wdata, ew);
        mem_done = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_done = 1'b0;
        if (w == 0) p0_req = 1'b0; else p1_req = 1'b0;
        check_eq("issue_end", 32'({p0_ack, p1_ack, mem_enable}), 0);
        to = (lat >= TO);
        ncyc = to ? TO : lat + 1;
        for (int c = 0; c < ncyc; c++) begin
            if (c == lat) begin
                mem_done = 1'b1;
                mem_rdata = rdata;
            end
            @(posedge clk); #1;
            mem_done = 1'b0;
            mem_rdata = $urandom;
            if (c < ncyc - 1) begin
                check_eq("wait_quiet", 32'({p0_done, p1_done, timeout, p0_ack, p1_ack}), 0);
                check_eq("wait_rd_hold", rd_data, exp_rd);
            end
        end
        if (to) exp_rd = 32'hFFFF_FFFF;
        else if (er) exp_rd = rdata;
        check_eq("p0_done", 32'(p0_done), 32'(w == 0));
        check_eq("p1_done", 32'(p1_done), 32'(w == 1));
        check_eq("timeout", 32'(timeout), 32'(to));
        check_eq("rd_data", rd_data, exp_rd);
        if (to && $urandom_range(0, 1) == 1) begin
            mem_done = 1'b1;  // late completion, arrives while idle
            mem_rdata = $urandom;
        end
    endtask

    task automatic idle_gap(input int n);
        for (int g = 0; g < n; g++) begin
            mem_done = $urandom_range(0, 1);
            mem_rdata = $urandom;
            @(posedge clk); #1;
            check_eq("idle_quiet", 32'({p0_ack, p1_ack, p0_done, p1_done, mem_enable, timeout}), 0);
            check_eq("idle_rd_hold", rd_data, exp_rd);
        end
        mem_done = 1'b0;
    endtask

    initial begin
        int lat;
        nrst = 1'b0;
        p0_req = 0; p0_addr = '0; p1_req = 0; p1_rwn = 0; p1_addr = '0; p1_wdata = 0;
        mem_done = 0; mem_rdata = 0;
        last_grant = 1;
        exp_rd = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        nrst = 1'b1;
        @(posedge clk); #1;

        // Port 0 fetch with a 5-cycle memory
        p0_req = 1; p0_addr = 27'h100;
        run_txn(4, 32'hDEAD_BEEF);
        // Port 1 write leaves rd_data alone
        p1_req = 1; p1_rwn = 0; p1_addr = 27'h2A; p1_wdata = 32'h1234_5678;
        run_txn(3, 32'hCAFE_F00D);
        // Port 1 read never answered: watchdog fires
        p1_req = 1; p1_rwn = 1; p1_addr = 27'h44;
        run_txn(TO + 5, 32'h0);
        idle_gap(2);
        // Both held for four transactions: strict alternation
        for (int k = 0; k < 4; k++) begin
            p0_req = 1; p1_req = 1;
            p0_addr = 27'(k * 16); p1_addr = 27'(k * 16 + 4); p1_rwn = 1;
            run_txn(k, 32'h1000 + 32'(k));
            check_eq("rr_order", 32'(last_grant), 32'(k % 2));
        end
        p0_req = 0; p1_req = 0;
        idle_gap(1);

        for (int it = 0; it < 200; it++) begin
            if (!p0_req && !p1_req && $urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
            if (!p0_req) begin
                p0_req = $urandom_range(0, 1);
                p0_addr = 27'($urandom);
            end
            if (!p1_req) begin
                p1_req = $urandom_range(0, 1);
                p1_addr = 27'($urandom);
                p1_rwn = $urandom_range(0, 1);
                p1_wdata = $urandom;
            end
            if (!p0_req && !p1_req) begin
                if ($urandom_range(0, 1) == 1) p0_req = 1; else p1_req = 1;
            end
            if ($urandom_range(0, 7) == 0) lat = TO + $urandom_range(0, 3);
            else lat = $urandom_range(0, TO - 1);
            run_txn(lat, $urandom);
        end
        p0_req = 0; p1_req = 0;
        idle_gap(2);

        // Reset in the middle of a wait drops the transaction
        p1_req = 1; p1_rwn = 1; p1_addr = 27'h3F; p1_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        p1_req = 0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        last_grant = 1;
        exp_rd = 32'd0;
        @(posedge clk); #1;
        nrst = 1'b1;
        for (int c = 0; c < TO + 3; c++) begin
            @(posedge clk); #1;
            check_eq("post_reset_quiet", 32'({p0_done, p1_done, timeout, mem_enable}), 0);
        end
        p0_req = 1; p1_req = 1; p0_addr = 27'h7; p1_addr = 27'h9; p1_rwn = 1;
        run_txn(2, 32'hABCD_0123);
        check_eq("post_reset_grant", 32'(last_grant), 0);
        p0_req = 0; p1_req = 0;
        idle_gap(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 27: width of every address bus.
REQ-002 SHALL have parameter TIMEOUT, default 1024: WAIT-state cycle limit; legal range 2..65535.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port nrst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port p0_req  input  1: port 0 (instruction fetch, read-only) request; held until p0_ack.
REQ-006 SHALL have port p0_addr  input  ADDR_WIDTH: port 0 read address.
REQ-007 SHALL have port p0_ack  output  1: one-cycle pulse; port 0 request accepted.
REQ-008 SHALL have port p0_done  output  1: one-cycle pulse; port 0 transaction complete, rd_data valid.
REQ-009 SHALL have port p1_req  input  1: port 1 (data) request; held until p1_ack.
REQ-010 SHALL have port p1_rwn  input  1: port 1 direction; 1 = read, 0 = write.
REQ-011 SHALL have port p1_addr  input  ADDR_WIDTH: port 1 address.
REQ-012 SHALL have port p1_wdata  input  32: port 1 write data.
REQ-013 SHALL have port p1_ack  output  1: one-cycle pulse; port 1 request accepted.
REQ-014 SHALL have port p1_done  output  1: one-cycle pulse; port 1 transaction complete.
REQ-015 SHALL have port rd_data  output  32: read data shared by both ports, valid in the pX_done cycle and held until the next completion.
REQ-016 SHALL have port mem_enable  output  1: one-cycle start pulse to the memory unit.
REQ-017 SHALL have port mem_rwn  output  1: latched direction, 1 = read.
REQ-018 SHALL have port mem_addr  output  ADDR_WIDTH: latched address.
REQ-019 SHALL have port mem_wdata  output  32: latched write data.
REQ-020 SHALL have port mem_rdata  input  32: memory read data, valid while mem_done = 1.
REQ-021 SHALL have port mem_done  input  1: memory unit completion pulse, for read and write.
REQ-022 SHALL have port timeout  output  1: one-cycle pulse; the active transaction was aborted by the watchdog.

Function
REQ-023 SHALL implement states IDLE, ISSUE and WAIT, fully registered; all outputs come from registers.
REQ-024 IDLE, any pX_req sampled high at a clock edge -> ISSUE: latch winner's addr/rwn/wdata into mem_addr/mem_rwn/mem_wdata; port 0 forces mem_rwn = 1 and mem_wdata = 0.
REQ-025 Arbitration SHALL be round-robin: a single requester wins; when both request, the port not granted last wins; last_grant updates on entry to ISSUE.
REQ-026 ISSUE SHALL last exactly one cycle: winner's pX_ack = 1 and mem_enable = 1; next state WAIT; the watchdog counter clears to 0.
REQ-027 WAIT, mem_done = 1 -> IDLE: next cycle owner's pX_done = 1; rd_data <= mem_rdata on reads only; rd_data unchanged on writes.
REQ-028 WAIT, no mem_done, counter == TIMEOUT-1 -> IDLE: next cycle owner's pX_done = 1, timeout = 1, rd_data <= 32'hFFFFFFFF.
REQ-029 WAIT, otherwise: counter increments by 1 (16-bit; never wraps given the TIMEOUT range).
REQ-030 mem_done in IDLE or ISSUE SHALL be ignored (no done, no rd_data update).
REQ-031 req still high during its own ack cycle SHALL NOT start a second transaction; IDLE evaluates requests every cycle, including the cycle in which pX_done is asserted.
REQ-032 Latency: req high at edge N -> ack/mem_enable in cycle N+1; mem_done at edge M -> pX_done in cycle M+1; back-to-back grants are 3 cycles apart minimum.
REQ-033 At most one of p0_ack, p1_ack SHALL be high in any cycle; likewise p0_done, p1_done.

Reset
REQ-034 nrst low SHALL immediately force IDLE, last_grant = port 1, counter = 0, all outputs 0 including rd_data, mem_addr and mem_wdata.
REQ-035 Reset during ISSUE or WAIT SHALL drop the transaction silently: no pX_done, no timeout after release.

Verification
REQ-036 p0_req only, addr 0x100; mem_done after 5 cycles with mem_rdata 0xDEADBEEF -> p0_ack once, mem_enable once with mem_addr 0x100 and mem_rwn 1; then p0_done with rd_data 0xDEADBEEF.
REQ-037 p0_req and p1_req both held for 4 transactions -> grants in order 0,1,0,1; the two acks are never high together.
REQ-038 p1 write, addr 0x2A, wdata 0x12345678 -> mem_rwn 0 and mem_wdata 0x12345678; p1_done; rd_data keeps its previous value.
REQ-039 TIMEOUT = 8, mem_done never asserted -> p1_done and timeout together, 8 cycles after the WAIT entry; rd_data 0xFFFFFFFF; a late mem_done is ignored.
REQ-040 nrst pulsed low mid-WAIT -> all outputs 0 at once; no done after release; the next dual request grants port 0.
